// File: rtl/spi_master_if.sv
// Request/response bundle between a host and spi_master.
// The host drives the request side, spi_master returns status.
interface spi_master_if;
  logic       start;
  logic       rw;
  logic [5:0] address;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;

  modport master (
    output start, rw, address, wr_data,
    input  busy, done, rd_data
  );

  modport slave (
    input  start, rw, address, wr_data,
    output busy, done, rd_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode 0 initiator: one 16-bit register read or write per request.
// Frame is {rw, 0, addr[5:0]} then data, MSB first; miso holds read data.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic       clock,
  input  logic       reset,
  spi_master_if.slave bus,
  output logic       spi_clk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, DONE, GAP
  } state_e;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
  localparam bit         NO_GAP     = (CS_GAP == 0);

  state_e      state_q;
  logic [15:0] sr_q;
  logic [7:0]  rx_q;
  logic [7:0]  rd_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic        rw_q;
  logic        busy_q;
  logic        done_q;
  logic        sclk_q;
  logic        csn_q;
  logic        mosi_q;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;
  assign spi_clk     = sclk_q;
  assign cs_n        = csn_q;
  assign mosi        = mosi_q;

  // Frame sequencer; every pin and status output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Reads shift out zeros in the data byte.
            sr_q    <= {bus.rw, 1'b0, bus.address,
                        bus.rw ? bus.wr_data : 8'h00};
            rw_q    <= bus.rw;
            mosi_q  <= bus.rw;
            csn_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              // Only byte-1 samples carry read data.
              if (bit_q[3]) begin
                rx_q <= {rx_q[6:0], miso};
              end
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 4'd15) begin
                state_q <= HOLD;
              end else begin
                bit_q  <= bit_q + 4'd1;
                sr_q   <= {sr_q[14:0], 1'b0};
                mosi_q <= sr_q[14];
              end
            end
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!rw_q) begin
              rd_q <= rx_q;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          if (NO_GAP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default and fast-timing instances checked
// each cycle against a timeline model built from frame arithmetic.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic [1:0] sclk;
  logic [1:0] csn;
  logic [1:0] mo;
  logic [1:0] mi = '0;
  logic [1:0] rnd_mi = '0;

  spi_master_if bus0 ();
  spi_master_if bus1 ();

  spi_master u0 (
    .clock  (clk),
    .reset  (rst0),
    .bus    (bus0.slave),
    .spi_clk(sclk[0]),
    .cs_n   (csn[0]),
    .mosi   (mo[0]),
    .miso   (mi[0])
  );

  spi_master #(
    .CLK_DIV (1),
    .CS_SETUP(1),
    .CS_HOLD (1),
    .CS_GAP  (0)
  ) u1 (
    .clock  (clk),
    .reset  (rst1),
    .bus    (bus1.slave),
    .spi_clk(sclk[1]),
    .cs_n   (csn[1]),
    .mosi   (mo[1]),
    .miso   (mi[1])
  );

  logic [1:0] ob_busy;
  logic [1:0] ob_done;
  logic [7:0] ob_rd [2];
  assign ob_busy  = {bus1.busy, bus0.busy};
  assign ob_done  = {bus1.done, bus0.done};
  assign ob_rd[0] = bus0.rd_data;
  assign ob_rd[1] = bus1.rd_data;

  int pS [2] = '{2, 1};
  int pD [2] = '{4, 1};
  int pH [2] = '{2, 1};
  int pG [2] = '{2, 0};

  // Model state per instance.
  bit          act [2] = '{0, 0};
  int          tst [2] = '{0, 0};
  logic [15:0] mfr [2];
  bit          mrw [2];
  logic [7:0]  rdx [2] = '{8'h00, 8'h00};
  logic [7:0]  slv [2] = '{8'h00, 8'h00};

  // Observed frame facts.
  logic [15:0] cap [2];
  int          nr [2] = '{0, 0};
  bit          csbad [2];
  int          done_at [2] = '{0, 0};
  int          blow_at [2] = '{0, 0};
  int          fall_at [2] = '{0, 0};
  int          last_r [2];
  int          pmin [2];
  int          pmax [2];
  logic [7:0]  rd_done [2];
  logic        p_sc [2] = '{0, 0};
  logic        p_cs [2] = '{1, 1};
  logic        p_bz [2] = '{0, 0};

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d",
               nm, a, e, cyc);
    end
  endtask

  // Pins expected k cycles into a frame:
  // {busy, done, cs_n, spi_clk, mosi}.
  function automatic logic [4:0] model_out(
    int k, int s, int d, int h, int g,
    logic [15:0] fr);
    logic bz, dn, cs, sc, m;
    int kd, j, b;
    bz = 0; dn = 0; cs = 1; sc = 0; m = 0;
    kd = s + 32 * d + h + 1;
    if (k >= 1 && k < kd) begin
      bz = 1;
      cs = 0;
      if (k <= s) begin
        m = fr[15];
      end else if (k <= s + 32 * d) begin
        j = k - s - 1;
        b = j / (2 * d);
        sc = (j % (2 * d)) >= d;
        m = fr[15 - b];
      end else begin
        m = fr[0];
      end
    end else if (k == kd) begin
      bz = 1;
      dn = 1;
    end else if (k > kd && k <= kd + g) begin
      bz = 1;
    end
    return {bz, dn, cs, sc, m};
  endfunction

  int          k;
  int          kd;
  int          b;
  logic [4:0]  e;

  // Per-cycle compare, capture and miso slave model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      k = act[i] ? cyc - tst[i] + 1 : -1;
      kd = pS[i] + 32 * pD[i] + pH[i] + 1;
      e = model_out(k, pS[i], pD[i], pH[i], pG[i],
                    mfr[i]);
      if (act[i] && k == kd && !mrw[i])
        rdx[i] = slv[i];
      chk($sformatf("pins%0d", i),
          {27'd0, ob_busy[i], ob_done[i], csn[i],
           sclk[i], mo[i]},
          {27'd0, e});
      chk($sformatf("rd%0d", i), {24'd0, ob_rd[i]},
          {24'd0, rdx[i]});
      if (csn[i])
        chk($sformatf("hyg%0d", i),
            {30'd0, sclk[i], mo[i]}, 32'd0);

      if (p_cs[i] && !csn[i]) begin
        nr[i] = 0;
        cap[i] = '0;
        csbad[i] = 0;
        fall_at[i] = cyc + 1;
        pmin[i] = 9999;
        pmax[i] = 0;
      end
      if (!p_sc[i] && sclk[i]) begin
        cap[i] = {cap[i][14:0], mo[i]};
        if (nr[i] > 0) begin
          if (cyc - last_r[i] < pmin[i])
            pmin[i] = cyc - last_r[i];
          if (cyc - last_r[i] > pmax[i])
            pmax[i] = cyc - last_r[i];
        end
        last_r[i] = cyc;
        nr[i]++;
        if (csn[i]) csbad[i] = 1;
      end
      if (ob_done[i]) begin
        done_at[i] = cyc + 1;
        rd_done[i] = ob_rd[i];
      end
      if (p_bz[i] && !ob_busy[i])
        blow_at[i] = cyc + 1;
      p_sc[i] = sclk[i];
      p_cs[i] = csn[i];
      p_bz[i] = ob_busy[i];

      b = nr[i];
      if (csn[i])
        mi[i] = rnd_mi[i];
      else if (b < 8)
        mi[i] = 1'b1;
      else if (b < 16)
        mi[i] = slv[i][15 - b];
      else
        mi[i] = 1'b0;
    end
  end

  task automatic at_neg(int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic st, logic r,
                         logic [5:0] a, logic [7:0] d);
    if (i == 0) begin
      bus0.start = st; bus0.rw = r;
      bus0.address = a; bus0.wr_data = d;
    end else begin
      bus1.start = st; bus1.rw = r;
      bus1.address = a; bus1.wr_data = d;
    end
  endtask

  // Pulse start for one edge; model accepts only when idle.
  task automatic go(int i, logic r, logic [5:0] a,
                    logic [7:0] d, output int t);
    int kk, kdd;
    set_req(i, 1'b1, r, a, d);
    kk = act[i] ? cyc - tst[i] + 1 : -1;
    kdd = pS[i] + 32 * pD[i] + pH[i] + 1;
    t = -1;
    if (kk < 1 || kk > kdd + pG[i]) begin
      act[i] = 1;
      tst[i] = cyc + 1;
      mfr[i] = {r, 1'b0, a, r ? d : 8'h00};
      mrw[i] = r;
      t = cyc + 1;
    end
    @(negedge clk); #1;
    set_req(i, 1'b0, r, a, d);
  endtask

  int t, t2, dsave;

  initial begin
    set_req(0, 1'b0, 1'b0, 6'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 6'h00, 8'h00);
    at_neg(3);
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk("rst_pins0", {csn[0], sclk[0], mo[0]}, 3'b100);
    chk("rst_stat0", {ob_busy[0], ob_done[0], ob_rd[0]},
        10'h000);
    chk("rst_pins1", {csn[1], sclk[1], mo[1]}, 3'b100);

    // Write 0xA5 to 0x05.
    at_neg(6);
    go(0, 1'b1, 6'h05, 8'hA5, t);
    at_neg(t + 140);
    chk("wr_frame", cap[0], 16'h85A5);
    chk("wr_rises", nr[0], 16);
    chk("wr_cs", csbad[0], 0);
    chk("wr_per", {pmin[0], pmax[0]}, {32'd8, 32'd8});
    chk("wr_done", done_at[0] - t, 133);
    chk("wr_busy", blow_at[0] - t, 136);
    chk("wr_rd", ob_rd[0], 8'h00);

    // Read 0x3F, slave returns 0x3C.
    slv[0] = 8'h3C;
    go(0, 1'b0, 6'h3F, 8'h77, t);
    at_neg(t + 140);
    chk("rd_frame", cap[0], 16'h3F00);
    chk("rd_at_done", rd_done[0], 8'h3C);
    chk("rd_done", done_at[0] - t, 133);
    chk("rd_busy", blow_at[0] - t, 136);

    // Starts during busy are dropped.
    go(0, 1'b1, 6'h12, 8'h34, t);
    at_neg(t + 9);
    go(0, 1'b0, 6'h2A, 8'hC3, t2);
    chk("ign10", t2, -1);
    at_neg(t + 99);
    go(0, 1'b1, 6'h01, 8'h01, t2);
    at_neg(t + 135);
    chk("ign_frame", cap[0], 16'h9234);
    go(0, 1'b1, 6'h0A, 8'h5A, t2);
    chk("ign_acc", t2 - t, 136);
    at_neg(t2 + 2);
    chk("ign_fall", fall_at[0] - t, 137);
    at_neg(t2 + 140);
    chk("ign_f2", cap[0], 16'h8A5A);

    // Reset in the middle of a read.
    chk("pre_rst_rd", ob_rd[0], 8'h3C);
    slv[0] = 8'h99;
    dsave = done_at[0];
    go(0, 1'b0, 6'h11, 8'h00, t);
    at_neg(t + 59);
    rst0 = 1'b1;
    act[0] = 0;
    rdx[0] = 8'h00;
    at_neg(t + 60);
    rst0 = 1'b0;
    chk("mr_pins", {csn[0], sclk[0], mo[0]}, 3'b100);
    chk("mr_busy", ob_busy[0], 1'b0);
    chk("mr_rd", ob_rd[0], 8'h00);
    at_neg(t + 200);
    chk("mr_nodone", done_at[0], dsave);
    go(0, 1'b1, 6'h2B, 8'h66, t);
    at_neg(t + 140);
    chk("mr_frame", cap[0], 16'hAB66);
    chk("mr_done", done_at[0] - t, 133);

    // Fast timing instance.
    go(1, 1'b1, 6'h00, 8'hFF, t);
    at_neg(t + 40);
    chk("f_frame", cap[1], 16'h80FF);
    chk("f_rises", nr[1], 16);
    chk("f_per", {pmin[1], pmax[1]}, {32'd2, 32'd2});
    chk("f_done", done_at[1] - t, 35);
    chk("f_busy", blow_at[1] - t, 36);
    slv[1] = 8'h5A;
    go(1, 1'b0, 6'h15, 8'hEE, t);
    at_neg(t + 40);
    chk("f_rframe", cap[1], 16'h1500);
    chk("f_rd", ob_rd[1], 8'h5A);

    // Random idle traffic with start low.
    for (int n = 0; n < 200; n++) begin
      bus0.rw = 1'($urandom);
      bus0.address = 6'($urandom);
      bus0.wr_data = 8'($urandom);
      bus1.rw = 1'($urandom);
      bus1.address = 6'($urandom);
      bus1.wr_data = 8'($urandom);
      rnd_mi = 2'($urandom);
      @(negedge clk); #1;
    end
    chk("idle_busy", ob_busy, 2'b00);
    chk("idle_cs", csn, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode 0 initiator: the master end of the team's SPI register-access link.
- Generates `spi_clk`, `cs_n` and `mosi`, and samples `miso`, to perform one 16-bit register read or write per request.
- Frame, MSB first: byte 0 = {rw, 1'b0, address[5:0]}, byte 1 = write data; during byte 1 of a read, `miso` returns the read data.
- Sits on the controller side (test harness or host-emulation FPGA) driving the slave `spi`/`reg_file` pair.

Parameters:
- CLK_DIV, 4, system clocks per SPI half-period; legal range 1..255.
- CS_SETUP, 2, clocks with `cs_n` low and `spi_clk` low before the first low phase; legal range 1..15.
- CS_HOLD, 2, clocks with `cs_n` low after the last falling `spi_clk`; legal range 1..15.
- CS_GAP, 2, minimum clocks with `cs_n` high after a frame before the next start is accepted; legal range 0..15.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- rw  in  1  1 = write, 0 = read; latched with start.
- address  in  6  register address; latched with start.
- wr_data  in  8  write data; latched with start, ignored for reads.
- busy  out  1  high from the cycle after start acceptance until back in IDLE.
- done  out  1  one-cycle pulse at frame completion.
- rd_data  out  8  last read result; updated only at done of a read.
- spi_clk  out  1  SPI clock; idles low (CPOL=0).
- cs_n  out  1  active-low chip select.
- mosi  out  1  master out.
- miso  in  1  master in; treated as synchronous to `clock`, no synchronizer inside.

Behaviour:
- Reset values of all outputs: `busy`=0, `done`=0, `rd_data`=8'h00, `spi_clk`=0, `cs_n`=1, `mosi`=0. State returns to IDLE.
- Reset mid-frame: on the next edge `cs_n` goes to 1 and `spi_clk` to 0. No `done` pulse; `rd_data` returns to 0. The partial frame is abandoned.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> GAP -> IDLE.
- IDLE:
  - `start`=1 at edge T latches {rw, address, wr_data} into a 16-bit shift register `sr`, then goes to SETUP.
  - At T+1: `cs_n`=0, `busy`=1, `mosi`=`sr[15]`.
- SETUP: holds CS_SETUP clocks with `spi_clk`=0, then goes to SHIFT.
- SHIFT: 16 bits, each a low phase of CLK_DIV clocks followed by a high phase of CLK_DIV clocks.
  - At the edge that drives `spi_clk` 0->1: `miso` is sampled into the receive register (rx[7:0] shifts left, new bit into LSB).
  - At the edge that drives `spi_clk` 1->0: `mosi` advances to the next bit.
  - After the 16th high phase, `spi_clk` returns to 0 and the state goes to HOLD.
  - Bit counter runs 0..15; it wraps only via the state transition, never free-running.
- Receive sampling: only the 8 samples of byte 1 are kept; byte-0 samples are discarded.
- HOLD: CS_HOLD clocks, `cs_n`=0, `spi_clk`=0, `mosi` holds bit 0.
- DONE (one cycle):
  - `cs_n`=1, `mosi`=0, `done`=1.
  - If a read, `rd_data` takes rx in this same cycle; a write leaves `rd_data` unchanged.
- GAP: CS_GAP clocks with `cs_n`=1. If CS_GAP=0, DONE goes directly to IDLE.
- `busy` drops on entry to IDLE; `start` is accepted in that same cycle.
- `start` while `busy`=1 is ignored: no queuing, latched fields unchanged.
- `mosi` is 0 whenever `cs_n`=1. `spi_clk` is never high while `cs_n`=1.
- Latency at defaults, start at edge T:
  - `cs_n` low T+1..T+132 (2+128+2 clocks).
  - `done` at T+133.
  - `busy` low at T+136; next start accepted at T+136.
  - General: `done` at T+1+CS_SETUP+32*CLK_DIV+CS_HOLD.
- CLK_DIV=1: `spi_clk` toggles every clock; the same ordering rules apply.

Test Plan:
- Write: start, rw=1, address=6'h05, wr_data=8'hA5 at defaults.
  - Captured mosi on 16 `spi_clk` rising edges = 16'h85A5.
  - Exactly 16 rising edges, all with `cs_n`=0.
  - `done` pulse at T+133; `rd_data` remains 8'h00.
- Read: rw=0, address=6'h3F; a slave model drives 8'h3C on `miso` after each falling edge in byte 1.
  - mosi frame = 16'h3F00.
  - `rd_data`=8'h3C in the `done` cycle; `busy` low at T+136.
- Start ignored when busy: start pulses at T+10 and T+100 with different address/data.
  - Only one frame is emitted, carrying the original fields.
  - A start at T+136 is accepted and `cs_n` falls at T+137.
- Reset mid-frame: assert reset at T+60.
  - At T+61: `cs_n`=1, `spi_clk`=0, `mosi`=0, `busy`=0, `rd_data`=0.
  - No `done`; a subsequent write completes normally.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_GAP=0: write 8'hFF to 6'h00.
  - mosi frame 16'h80FF; `spi_clk` period 2 clocks.
  - `done` at T+35; `busy` low at T+36.
- Idle hygiene: over random stimulus with start held low, `spi_clk` is never 1 while `cs_n`=1, and `mosi`=0 whenever `cs_n`=1.
